// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: load-use, MD-unit busy, branch squash and memory-wait freeze for the 5-stage pipe.
// Enables/flushes are combinational (0 cycles); a memory wait freezes every stage until mem_ready.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 4,
  parameter int MD_LATENCY  = 8,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  id_is_md,
  input  logic                  id_reads_hilo,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_flush,
  output logic                  ex_mem_write,
  output logic                  mem_wb_write,
  output logic                  md_busy,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [7:0]        md_cnt_q, md_cnt_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  logic load_use, md_hazard, mem_stall;
  logic freeze, flush, stall, normal, md_issue;

  assign md_busy   = (md_cnt_q != 8'd0);
  assign load_use  = id_ex_mem_read && (id_ex_rd != '0) &&
                     ((id_uses_rs && (id_rs == id_ex_rd)) || (id_uses_rt && (id_rt == id_ex_rd)));
  assign md_hazard = md_busy && (id_is_md || id_reads_hilo);
  assign mem_stall = mem_req && !mem_ready;

  // Mode decode is qualified by rst_n so nothing advances or counts while in reset.
  assign freeze   = rst_n && mem_stall;
  assign flush    = rst_n && !mem_stall && ex_branch_taken;
  assign stall    = rst_n && !mem_stall && !ex_branch_taken && (md_hazard || load_use);
  assign normal   = rst_n && !mem_stall && !ex_branch_taken && !md_hazard && !load_use;
  assign md_issue = normal && id_is_md;

  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b0;
    mem_wb_write = 1'b0;
    if (flush) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
    end else if (stall) begin
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
    end else if (normal) begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
    end
  end

  always_comb begin
    md_cnt_d       = md_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;

    // The MD unit runs on its own, so the countdown continues through freezes.
    if (md_issue)
      md_cnt_d = 8'(MD_LATENCY);
    else if (md_busy)
      md_cnt_d = md_cnt_q - 8'd1;

    if (!mem_stall)
      wait_cnt_d = '0;
    else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1))
      mem_timeout_d = 1'b1;
    else
      wait_cnt_d = wait_cnt_q + 1'b1;

    if ((freeze || stall) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (flush && (flush_count_q != '1))
      flush_count_d = flush_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt_q       <= 8'd0;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      md_cnt_q       <= md_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a vector table for the combinational modes,
// then hand-written sequences for MD occupancy, memory wait, watchdog, saturation and reset.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 8;
  // Output bundle order: pc, if_id_w, if_id_flush, id_ex_w, id_ex_flush, ex_mem_w, mem_wb_w
  localparam logic [6:0] M_FREEZE = 7'b000_0000;
  localparam logic [6:0] M_FLUSH  = 7'b111_1111;
  localparam logic [6:0] M_STALL  = 7'b000_1111;
  localparam logic [6:0] M_NORMAL = 7'b110_1011;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] id_rs, id_rt, id_ex_rd;
  logic id_uses_rs, id_uses_rt, id_ex_mem_read, id_is_md, id_reads_hilo;
  logic ex_branch_taken, mem_req, mem_ready;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write;
  logic md_busy, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [6:0] outs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(4), .MD_LATENCY(8), .MEM_TIMEOUT(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .id_is_md(id_is_md), .id_reads_hilo(id_reads_hilo),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .md_busy(md_busy), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  assign outs = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write};

  typedef struct {
    logic [3:0] rs, rt, ex_rd;
    logic       uses_rs, uses_rt, ex_load, is_md, reads_hilo, br, mreq, mrdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 4'd0; id_rt = 4'd0; id_ex_rd = 4'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_ex_mem_read = 1'b0;
    id_is_md = 1'b0; id_reads_hilo = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    chk("rst_enables", 32'(outs), 32'(M_FREEZE));
    tick();
    rst_n = 1'b1;
    #3;
  endtask

  initial begin
    //            rs     rt     ex_rd  urs   urt   load  md    hilo  br    mreq  mrdy  expected
    vecs[0]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_NORMAL};
    vecs[1]  = '{4'd3, 4'd1, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_STALL};
    vecs[2]  = '{4'd2, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_STALL};
    vecs[3]  = '{4'd3, 4'd1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_NORMAL};
    vecs[4]  = '{4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_NORMAL};
    vecs[5]  = '{4'd3, 4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_NORMAL};
    vecs[6]  = '{4'd3, 4'd1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, M_FLUSH};
    vecs[7]  = '{4'd3, 4'd1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, M_FREEZE};
    vecs[8]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, M_NORMAL};
    vecs[9]  = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, M_NORMAL};
    vecs[10] = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, M_FREEZE};

    rst_n = 1'b0;
    do_reset();
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    chk("rst_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rst_flush_count", 32'(flush_count), 32'd0);
    chk("rst_mem_timeout", 32'(mem_timeout), 32'd0);

    for (int i = 0; i < 11; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_ex_rd = vecs[i].ex_rd;
      id_uses_rs = vecs[i].uses_rs; id_uses_rt = vecs[i].uses_rt;
      id_ex_mem_read = vecs[i].ex_load; id_is_md = vecs[i].is_md;
      id_reads_hilo = vecs[i].reads_hilo; ex_branch_taken = vecs[i].br;
      mem_req = vecs[i].mreq; mem_ready = vecs[i].mrdy;
      #3;
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
      tick();
    end

    // Load-use, then the dependent instruction proceeds.
    do_reset();
    id_ex_mem_read = 1'b1; id_ex_rd = 4'd3; id_rs = 4'd3; id_uses_rs = 1'b1;
    #3 chk("lu_stall", 32'(outs), 32'(M_STALL));
    tick();
    id_ex_mem_read = 1'b0;
    #3 chk("lu_release", 32'(outs), 32'(M_NORMAL));
    chk("lu_stall_cycles", 32'(stall_cycles), 32'd1);
    tick();

    // Branch taken together with a load-use hazard squashes instead of stalling.
    id_ex_mem_read = 1'b1; ex_branch_taken = 1'b1;
    #3 chk("br_lu_flush", 32'(outs), 32'(M_FLUSH));
    tick();
    idle();
    #3 chk("br_flush_count", 32'(flush_count), 32'd1);
    chk("br_stall_cycles", 32'(stall_cycles), 32'd1);

    // mult issue followed by mflo.
    id_is_md = 1'b1;
    #3 chk("md_issue_normal", 32'(outs), 32'(M_NORMAL));
    tick();
    id_is_md = 1'b0; id_reads_hilo = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #3;
      chk($sformatf("md_busy_c%0d", c), 32'(md_busy), 32'd1);
      chk($sformatf("md_stall_c%0d", c), 32'(outs), 32'(M_STALL));
      tick();
    end
    #3 chk("md_busy_fall", 32'(md_busy), 32'd0);
    chk("md_mflo_go", 32'(outs), 32'(M_NORMAL));
    chk("md_stall_cycles", 32'(stall_cycles), 32'd9);
    tick();

    // Memory wait of 3 cycles while md_cnt=5: the MD countdown continues.
    idle();
    id_is_md = 1'b1;
    tick();
    id_is_md = 1'b0;
    repeat (3) tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #3 chk($sformatf("mw_freeze_c%0d", c), 32'(outs), 32'(M_FREEZE));
      tick();
    end
    mem_ready = 1'b1;
    #3 chk("mw_busy_2left", 32'(md_busy), 32'd1);
    chk("mw_no_timeout", 32'(mem_timeout), 32'd0);
    chk("mw_stall_cycles", 32'(stall_cycles), 32'd12);
    tick();
    #3 chk("mw_busy_1left", 32'(md_busy), 32'd1);
    tick();
    #3 chk("mw_busy_done", 32'(md_busy), 32'd0);

    // Watchdog: timeout rises on the 4th consecutive wait edge and sticks.
    mem_ready = 1'b0;
    repeat (3) tick();
    #3 chk("wd_before", 32'(mem_timeout), 32'd0);
    tick();
    #3 chk("wd_set", 32'(mem_timeout), 32'd1);
    mem_ready = 1'b1;
    tick();
    #3 chk("wd_sticky", 32'(mem_timeout), 32'd1);
    chk("wd_resume", 32'(outs), 32'(M_NORMAL));
    chk("wd_stall_cycles", 32'(stall_cycles), 32'd16);

    // Long freeze: counter saturates, freeze persists after the timeout.
    mem_ready = 1'b0;
    repeat (260) tick();
    #3 chk("sat_stall_cycles", 32'(stall_cycles), 32'd255);
    chk("sat_still_frozen", 32'(outs), 32'(M_FREEZE));

    // Reset in the middle of an MD operation.
    idle();
    tick();
    id_is_md = 1'b1;
    tick();
    id_is_md = 1'b0;
    repeat (4) tick();
    #3 chk("rmd_busy_before", 32'(md_busy), 32'd1);
    rst_n = 1'b0;
    #1 chk("rmd_enables_off", 32'(outs), 32'(M_FREEZE));
    tick();
    rst_n = 1'b1;
    id_reads_hilo = 1'b1;
    #3 chk("rmd_busy_cleared", 32'(md_busy), 32'd0);
    chk("rmd_stall_cycles", 32'(stall_cycles), 32'd0);
    chk("rmd_flush_count", 32'(flush_count), 32'd0);
    chk("rmd_mem_timeout", 32'(mem_timeout), 32'd0);
    chk("rmd_normal", 32'(outs), 32'(M_NORMAL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 16-bit MIPS pipeline. It sits beside the forwarding logic and covers the hazards forwarding cannot resolve:
- load-use RAW hazards;
- conflicts with the multi-cycle multiply/divide unit;
- taken-branch squash;
- data-memory wait states.
It drives the write enables and flush controls of the PC and every pipeline register, keeps a multiply/divide occupancy counter and a memory-wait watchdog, and exports performance counters.

Parameters:
REG_ADDR_W, 4, register address width (16-entry register file; register 0 hardwired zero)
MD_LATENCY, 8, cycles the multiply/divide unit stays busy after an MD instruction leaves ID (legal range 1..255)
MEM_TIMEOUT, 64, consecutive memory-wait cycles before mem_timeout is raised
CNT_W, 16, performance counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, synchronous, active-low
id_rs  in  REG_ADDR_W  source register rs of the instruction in ID
id_rt  in  REG_ADDR_W  source register rt of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
id_ex_mem_read  in  1  instruction in EX is a load
id_is_md  in  1  ID instruction is a multiply/divide
id_reads_hilo  in  1  ID instruction reads the MD result (mfhi/mflo)
ex_branch_taken  in  1  branch or jump resolved taken in EX
mem_req  in  1  MEM stage is performing a data access
mem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  clear IF/ID to NOP
id_ex_write  out  1  ID/EX register enable
id_ex_flush  out  1  load NOP bubble into ID/EX
ex_mem_write  out  1  EX/MEM register enable
mem_wb_write  out  1  MEM/WB register enable
md_busy  out  1  multiply/divide unit occupied
mem_timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  cycles with pc_write=0, excluding reset cycles
flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- Hazard terms, all combinational:
  - load_use = id_ex_mem_read && id_ex_rd!=0 && ((id_uses_rs && id_rs==id_ex_rd) || (id_uses_rt && id_rt==id_ex_rd))
  - md_hazard = md_busy && (id_is_md || id_reads_hilo)
  - mem_stall = mem_req && !mem_ready
- Priority: mem_stall > ex_branch_taken > md_hazard > load_use > normal. Enables and flushes are combinational (same cycle).
- FREEZE (mem_stall): all five write enables 0; both flushes 0.
- FLUSH (branch): all write enables 1; if_id_flush=1; id_ex_flush=1. Any simultaneous load_use or md_hazard is discarded, because the ID instruction is squashed.
- STALL (md_hazard or load_use): pc_write=0; if_id_write=0; id_ex_write=1 with id_ex_flush=1 to insert a bubble; ex_mem_write=1; mem_wb_write=1.
- Normal: all write enables 1; flushes 0.
- MD occupancy counter md_cnt (8 bits); md_busy = (md_cnt!=0).
  - An MD instruction issues when id_is_md=1 in a Normal cycle.
  - On issue, md_cnt loads MD_LATENCY at the next edge.
  - Otherwise md_cnt decrements each cycle while nonzero, including FREEZE cycles, since the MD unit runs independently.
  - Issue cannot coincide with md_busy, because that case is an md_hazard.
- Watchdog:
  - wait_cnt increments on each mem_stall cycle and clears on any cycle without mem_stall.
  - When wait_cnt reaches MEM_TIMEOUT-1 while mem_stall is still high, mem_timeout is set at that edge.
  - mem_timeout is sticky; only reset clears it.
  - The freeze continues regardless of mem_timeout.
- Counters:
  - stall_cycles increments in FREEZE and STALL cycles.
  - flush_count increments in FLUSH cycles.
  - Both saturate at all-ones and do not wrap.
- Reset (rst_n=0 at a rising edge): md_cnt, wait_cnt, mem_timeout, stall_cycles and flush_count all go to 0.
  - While rst_n=0, all write enables are forced to 0, flushes are 0, and counters do not count.
  - Reset asserted mid-MD or mid-wait aborts the operation; the first cycle after release is Normal unless the inputs raise a hazard.
- Register 0 never causes a load_use stall.

Test Plan:
- Load-use: EX lw r3 (id_ex_mem_read=1, id_ex_rd=3), ID add reads rs=3 -> one cycle pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (EX no longer a load) all enables 1; stall_cycles=1.
- Load to r0: id_ex_rd=0, id_rs=0, id_uses_rs=1 -> no stall, all enables 1.
- MD: issue mult with MD_LATENCY=8, then mflo in ID the following cycle -> md_busy=1 for exactly 8 cycles and mflo stalled 8 cycles; mflo advances on the cycle md_busy falls; stall_cycles=8.
- Branch during load-use: ex_branch_taken=1 with load_use=1 -> FLUSH (if_id_flush=1, id_ex_flush=1, pc_write=1); flush_count=1; stall_cycles unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles during md_busy (md_cnt=5) -> all enables 0 for 3 cycles; md_cnt=2 afterwards; mem_timeout stays 0. With MEM_TIMEOUT=4 and 4 wait cycles -> mem_timeout=1 and it stays 1 after mem_ready.
- Reset mid-MD: rst_n=0 for one edge at md_cnt=4 -> md_busy=0, counters 0, mem_timeout=0; enables 0 during reset, 1 after release.
